spi_controller: RTL

SPI_CONTROLLER -- requirements
Module: spi_controller

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_clk_div.sv | 39 +++
 rtl/spi_controller.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI controller: FSM state encoding, register map,
// STATUS/CTRL bit positions and the reset value of the clock divider.
package spi_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSclkLo,
        StSclkHi
    } spi_state_e;

    // Register addresses (addr 3 is reserved)
    localparam logic [1:0] AddrData   = 2'd0;
    localparam logic [1:0] AddrStatus = 2'd1;
    localparam logic [1:0] AddrDiv    = 2'd2;

    // STATUS/CTRL bit positions
    localparam int unsigned StatusBusy = 0;
    localparam int unsigned StatusDone = 1;
    localparam int unsigned StatusColl = 2;
    localparam int unsigned StatusIe   = 6;
    localparam int unsigned StatusCsN  = 7;

    localparam logic [7:0] DivReset = 8'h02;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period counter for the SPI engine.
// Ports:
//   clk, reset : bus clock, synchronous active-high reset
//   run        : engine is mid-transfer; while low the counter preloads div
//   div        : half-period length minus one
//   tick       : high for the last cycle of each half-period
module spi_clk_div
    import spi_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [7:0] div,
    output logic       tick
);

    logic [7:0] cnt_q, cnt_d;

    // Preloading while idle means the first half-period starts at DIV the
    // moment the engine leaves IDLE. Reloads read div live, so a DIV write
    // during a transfer lands at the next half-period boundary.
    always_comb begin
        cnt_d = cnt_q - 8'd1;
        if (!run || cnt_q == 8'd0) begin
            cnt_d = div;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= DivReset;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = run && (cnt_q == 8'd0);

endmodule

// File: rtl/spi_controller.sv
// CPU-bus SPI master (mode 0) with DATA, STATUS/CTRL and DIV registers.
// Ports:
//   clk, reset         : bus clock, synchronous active-high reset
//   cs, rwb, addr      : register access strobe, 1 = read, register select
//   i_data, o_data     : write data in, combinational read data out
//   irqb               : active-low interrupt, ~(done & ie)
//   spi_sclk, spi_mosi : SPI clock and serial data out
//   spi_miso           : serial data in
//   spi_cs_n           : slave select, software controlled via CTRL[7]
module spi_controller
    import spi_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    input  logic       cs,
    input  logic       rwb,
    input  logic [1:0] addr,
    output logic       irqb,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_cs_n
);

    spi_state_e state_q, state_d;

    logic [7:0] tx_q;
    logic [7:0] rx_sh_q;
    logic [7:0] rx_data_q;
    logic [7:0] div_q;
    logic [2:0] bit_cnt_q;
    logic       done_q;
    logic       coll_q;
    logic       ie_q;
    logic       cs_n_q;

    logic busy;
    logic tick;
    logic wr_data, wr_ctrl, wr_div;
    logic rd_data, rd_status;
    logic start, rise, fall, last_fall;

    // Bus decode
    assign wr_data   = cs && !rwb && (addr == AddrData);
    assign wr_ctrl   = cs && !rwb && (addr == AddrStatus);
    assign wr_div    = cs && !rwb && (addr == AddrDiv);
    assign rd_data   = cs &&  rwb && (addr == AddrData);
    assign rd_status = cs &&  rwb && (addr == AddrStatus);

    assign start     = wr_data && (state_q == StIdle);
    assign rise      = tick && (state_q == StSclkLo);
    assign fall      = tick && (state_q == StSclkHi);
    assign last_fall = fall && (bit_cnt_q == 3'd7);

    spi_clk_div u_clk_div (
        .clk   (clk),
        .reset (reset),
        .run   (busy),
        .div   (div_q),
        .tick  (tick)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start) state_d = StSclkLo;
            StSclkLo: if (tick)  state_d = StSclkHi;
            StSclkHi: if (tick)  state_d = last_fall ? StIdle : StSclkLo;
            default:             state_d = StIdle;
        endcase
    end

    // FSM: outputs. SCLK is decoded from state so reset forces it low at once.
    always_comb begin
        busy     = (state_q != StIdle);
        spi_sclk = (state_q == StSclkHi);
    end

    // Datapath and register file
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_q      <= 8'h00;
            rx_sh_q   <= 8'h00;
            rx_data_q <= 8'h00;
            div_q     <= DivReset;
            bit_cnt_q <= 3'd0;
            done_q    <= 1'b0;
            coll_q    <= 1'b0;
            ie_q      <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            if (start) begin
                tx_q      <= i_data;
                bit_cnt_q <= 3'd0;
            end
            if (rise) begin
                rx_sh_q <= {rx_sh_q[6:0], spi_miso};
            end
            if (fall) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                // The final falling edge leaves tx_q alone so MOSI keeps the last bit
                if (!last_fall) begin
                    tx_q <= {tx_q[6:0], 1'b0};
                end
            end
            if (last_fall) begin
                rx_data_q <= rx_sh_q;
            end

            // done: completion beats a coincident DATA read
            if (start) begin
                done_q <= 1'b0;
            end else if (last_fall) begin
                done_q <= 1'b1;
            end else if (rd_data) begin
                done_q <= 1'b0;
            end

            if (wr_data && busy) begin
                coll_q <= 1'b1;
            end else if (rd_status) begin
                coll_q <= 1'b0;
            end

            if (wr_ctrl) begin
                ie_q   <= i_data[StatusIe];
                cs_n_q <= i_data[StatusCsN];
            end
            if (wr_div) begin
                div_q <= i_data;
            end
        end
    end

    assign spi_mosi = tx_q[7];
    assign spi_cs_n = cs_n_q;
    assign irqb     = ~(done_q & ie_q);

    // Read mux, combinational from addr
    always_comb begin
        o_data = 8'h00;
        case (addr)
            AddrData:   o_data = rx_data_q;
            AddrStatus: begin
                o_data[StatusBusy] = busy;
                o_data[StatusDone] = done_q;
                o_data[StatusColl] = coll_q;
                o_data[StatusIe]   = ie_q;
                o_data[StatusCsN]  = cs_n_q;
            end
            AddrDiv:    o_data = div_q;
            default:    o_data = 8'h00;
        endcase
    end

endmodule
